// File: rtl/serial_config_scheduler.sv
// Sequences the TDC serial configuration shifter: arbitrates host requests against a
// periodic SEU-test reprogram, latches the image, starts the shifter and waits for done.
module serial_config_scheduler #(
    parameter int unsigned NREG            = 13,
    parameter int unsigned PRESCALE_W      = 26,
    parameter int unsigned TIMEOUT         = 4096,
    // Reset value of the programming counter (normally zero)
    parameter logic [15:0] PROG_COUNT_INIT = 16'h0000
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic              auto_en,
    input  logic              err_clr,
    input  logic [8*NREG-1:0] cfg_host,
    input  logic [8*NREG-1:0] cfg_s0,
    input  logic [8*NREG-1:0] cfg_s1,
    input  logic              shift_done,
    output logic              shift_start,
    output logic [8*NREG-1:0] cfg_out,
    output logic [1:0]        cfg_sel,
    output logic              busy,
    output logic              done_pulse,
    output logic [15:0]       prog_count,
    output logic              timeout_err,
    output logic              overrun
);

    localparam int unsigned   TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [15:0]   COUNT_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  host_req_q;
    logic                  host_pend_q, host_pend_d;
    logic                  auto_pend_q, auto_pend_d;
    logic                  alt_q, alt_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [8*NREG-1:0]     cfg_out_q, cfg_out_d;
    logic [1:0]            cfg_sel_q, cfg_sel_d;
    logic                  shift_start_q, shift_start_d;
    logic                  busy_q, busy_d;
    logic                  done_pulse_q, done_pulse_d;
    logic [15:0]           prog_count_q, prog_count_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  overrun_q, overrun_d;

    logic                  host_edge;
    logic                  tick;
    logic                  host_take;
    logic                  auto_take;
    logic                  timeout_hit;

    always_comb begin
        host_edge = host_req & ~host_req_q;
        tick      = auto_en & (presc_q == '1);
        presc_d   = auto_en ? presc_q + PRESCALE_W'(1) : '0;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            host_req_q    <= 1'b0;
            host_pend_q   <= 1'b0;
            auto_pend_q   <= 1'b0;
            alt_q         <= 1'b0;
            presc_q       <= '0;
            timer_q       <= '0;
            cfg_out_q     <= '0;
            cfg_sel_q     <= 2'd0;
            shift_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_pulse_q  <= 1'b0;
            prog_count_q  <= PROG_COUNT_INIT;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            host_req_q    <= host_req;
            host_pend_q   <= host_pend_d;
            auto_pend_q   <= auto_pend_d;
            alt_q         <= alt_d;
            presc_q       <= presc_d;
            timer_q       <= timer_d;
            cfg_out_q     <= cfg_out_d;
            cfg_sel_q     <= cfg_sel_d;
            shift_start_q <= shift_start_d;
            busy_q        <= busy_d;
            done_pulse_q  <= done_pulse_d;
            prog_count_q  <= prog_count_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    // Sequencer: host wins arbitration; images are captured only on leaving IDLE
    always_comb begin
        state_d      = state_q;
        host_take    = 1'b0;
        auto_take    = 1'b0;
        timeout_hit  = 1'b0;
        alt_d        = alt_q;
        timer_d      = timer_q;
        cfg_out_d    = cfg_out_q;
        cfg_sel_d    = cfg_sel_q;
        prog_count_d = prog_count_q;

        case (state_q)
            S_IDLE: begin
                if (host_pend_q) begin
                    host_take = 1'b1;
                    cfg_out_d = cfg_host;
                    cfg_sel_d = 2'd0;
                    state_d   = S_LATCH;
                end else if (auto_pend_q) begin
                    auto_take = 1'b1;
                    cfg_out_d = alt_q ? cfg_s1 : cfg_s0;
                    cfg_sel_d = alt_q ? 2'd2 : 2'd1;
                    alt_d     = ~alt_q;
                    state_d   = S_LATCH;
                end
            end
            S_LATCH: state_d = S_START;
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (shift_done) begin
                    if (prog_count_q != COUNT_MAX) begin
                        prog_count_d = prog_count_q + 16'd1;
                    end
                    state_d = S_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d        = (state_d != S_IDLE);
        shift_start_d = (state_d == S_START);
        done_pulse_d  = (state_d == S_DONE);
    end

    // A new event beats a same-cycle clear, so nothing is lost in the handoff
    always_comb begin
        host_pend_d   = host_edge | (host_pend_q & ~host_take);
        auto_pend_d   = tick | (auto_pend_q & ~auto_take);
        overrun_d     = (host_edge & host_pend_q) | (tick & auto_pend_q) | (overrun_q & ~err_clr);
        timeout_err_d = timeout_hit | (timeout_err_q & ~err_clr);
    end

    assign shift_start = shift_start_q;
    assign cfg_out     = cfg_out_q;
    assign cfg_sel     = cfg_sel_q;
    assign busy        = busy_q;
    assign done_pulse  = done_pulse_q;
    assign prog_count  = prog_count_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_serial_config_scheduler.sv
// Directed bench for serial_config_scheduler with PRESCALE_W=4 and TIMEOUT=8:
// a vector table for host programming/overrun plus sequences for timing corner cases.
module tb_serial_config_scheduler;

    localparam int NREG = 13;
    localparam int W    = 8 * NREG;
    localparam int NV   = 29;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         host_req;
    logic         auto_en;
    logic         err_clr;
    logic         done_man;
    logic         done_model;
    logic         model_en;
    logic         shift_done;
    logic [W-1:0] img_host, img_s0, img_s1, img_keep;

    logic         shift_start, busy, done_pulse, timeout_err, overrun;
    logic [W-1:0] cfg_out;
    logic [1:0]   cfg_sel;
    logic [15:0]  prog_count;

    logic         s_shift_start, s_busy, s_done_pulse, s_timeout_err, s_overrun;
    logic [W-1:0] s_cfg_out;
    logic [1:0]   s_cfg_sel;
    logic [15:0]  s_prog_count;

    assign shift_done = done_man | done_model;

    serial_config_scheduler #(.NREG(NREG), .PRESCALE_W(4), .TIMEOUT(8)) dut (
        .clkin(clk), .rst_n(rst_n), .host_req(host_req), .auto_en(auto_en),
        .err_clr(err_clr), .cfg_host(img_host), .cfg_s0(img_s0), .cfg_s1(img_s1),
        .shift_done(shift_done), .shift_start(shift_start), .cfg_out(cfg_out),
        .cfg_sel(cfg_sel), .busy(busy), .done_pulse(done_pulse),
        .prog_count(prog_count), .timeout_err(timeout_err), .overrun(overrun)
    );

    // Same stimulus, counter starting just below saturation
    serial_config_scheduler #(.NREG(NREG), .PRESCALE_W(4), .TIMEOUT(8),
                              .PROG_COUNT_INIT(16'hFFFD)) u_sat (
        .clkin(clk), .rst_n(rst_n), .host_req(host_req), .auto_en(auto_en),
        .err_clr(err_clr), .cfg_host(img_host), .cfg_s0(img_s0), .cfg_s1(img_s1),
        .shift_done(shift_done), .shift_start(s_shift_start), .cfg_out(s_cfg_out),
        .cfg_sel(s_cfg_sel), .busy(s_busy), .done_pulse(s_done_pulse),
        .prog_count(s_prog_count), .timeout_err(s_timeout_err), .overrun(s_overrun)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] img(input int code);
        case (code)
            0:       return img_host;
            1:       return img_s0;
            2:       return img_s1;
            default: return '0;
        endcase
    endfunction

    // Shifter model: raises done so that it is sampled three edges after start is seen
    int model_cd = 0;
    always @(posedge clk) begin
        #1;
        done_model = 1'b0;
        if (!model_en) model_cd = 0;
        if (model_cd != 0) begin
            model_cd--;
            if (model_cd == 0) done_model = 1'b1;
        end
        if (model_en && shift_start) model_cd = 2;
    end

    task automatic do_reset();
        host_req = 1'b0;
        auto_en  = 1'b0;
        err_clr  = 1'b0;
        done_man = 1'b0;
        model_en = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic host_frame();
        host_req = 1'b1;
        step();
        host_req = 1'b0;
        step();
        step();
        step();
        done_man = 1'b1;
        step();
        done_man = 1'b0;
        step();
    endtask

    typedef struct {
        int h, a, c, d;
        int busy, start, done, sel, cnt, terr, ovr, cfg;
    } vec_t;
    vec_t tbl [0:NV-1];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1);
    end

    initial begin
        int n_ev;

        //          h a c d  busy st dn sel cnt te ov cfg
        tbl[0]  = '{1,0,0,0, 0,0,0,0,0,0,0,3};
        tbl[1]  = '{1,0,0,0, 1,0,0,0,0,0,0,0};
        tbl[2]  = '{1,0,0,0, 1,1,0,0,0,0,0,0};
        tbl[3]  = '{1,0,0,0, 1,0,0,0,0,0,0,0};
        tbl[4]  = '{1,0,0,0, 1,0,0,0,0,0,0,0};
        tbl[5]  = '{1,0,0,0, 1,0,0,0,0,0,0,0};
        tbl[6]  = '{1,0,0,0, 1,0,0,0,0,0,0,0};
        tbl[7]  = '{1,0,0,0, 1,0,0,0,0,0,0,0};
        tbl[8]  = '{1,0,0,0, 1,0,0,0,0,0,0,0};
        tbl[9]  = '{1,0,0,0, 1,0,0,0,0,0,0,0};
        tbl[10] = '{1,0,0,1, 1,0,1,0,1,0,0,0};
        tbl[11] = '{1,0,0,0, 0,0,0,0,1,0,0,0};
        tbl[12] = '{0,0,0,0, 0,0,0,0,1,0,0,0};
        tbl[13] = '{1,0,0,0, 0,0,0,0,1,0,0,0};
        tbl[14] = '{1,0,0,0, 1,0,0,0,1,0,0,0};
        tbl[15] = '{0,0,0,0, 1,1,0,0,1,0,0,0};
        tbl[16] = '{1,0,0,0, 1,0,0,0,1,0,0,0};
        tbl[17] = '{0,0,0,0, 1,0,0,0,1,0,0,0};
        tbl[18] = '{1,0,0,0, 1,0,0,0,1,0,1,0};
        tbl[19] = '{0,0,0,1, 1,0,1,0,2,0,1,0};
        tbl[20] = '{0,0,0,0, 0,0,0,0,2,0,1,0};
        tbl[21] = '{0,0,0,0, 1,0,0,0,2,0,1,0};
        tbl[22] = '{0,0,0,0, 1,1,0,0,2,0,1,0};
        tbl[23] = '{0,0,0,0, 1,0,0,0,2,0,1,0};
        tbl[24] = '{0,0,0,1, 1,0,1,0,3,0,1,0};
        tbl[25] = '{0,0,0,0, 0,0,0,0,3,0,1,0};
        tbl[26] = '{0,0,0,0, 0,0,0,0,3,0,1,0};
        tbl[27] = '{0,0,1,0, 0,0,0,0,3,0,0,0};
        tbl[28] = '{0,0,0,0, 0,0,0,0,3,0,0,0};

        for (int i = 0; i < NREG; i++) begin
            img_host[8*i +: 8] = 8'(8'h10 + i);
            img_s0[8*i +: 8]   = 8'(8'h40 + i);
            img_s1[8*i +: 8]   = 8'(8'h80 + i);
        end
        host_req = 1'b0; auto_en = 1'b0; err_clr = 1'b0;
        done_man = 1'b0; model_en = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst busy",  W'(busy),        '0);
        chk("rst start", W'(shift_start), '0);
        chk("rst done",  W'(done_pulse),  '0);
        chk("rst sel",   W'(cfg_sel),     '0);
        chk("rst cnt",   W'(prog_count),  '0);
        chk("rst terr",  W'(timeout_err), '0);
        chk("rst ovr",   W'(overrun),     '0);
        chk("rst cfg",   cfg_out,         '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Host programming, then two edges during one WAIT and err_clr
        for (int i = 0; i < NV; i++) begin
            host_req = (tbl[i].h != 0);
            auto_en  = (tbl[i].a != 0);
            err_clr  = (tbl[i].c != 0);
            done_man = (tbl[i].d != 0);
            step();
            chk($sformatf("v%0d busy", i),  W'(busy),        W'(tbl[i].busy));
            chk($sformatf("v%0d start", i), W'(shift_start), W'(tbl[i].start));
            chk($sformatf("v%0d done", i),  W'(done_pulse),  W'(tbl[i].done));
            chk($sformatf("v%0d sel", i),   W'(cfg_sel),     W'(tbl[i].sel));
            chk($sformatf("v%0d cnt", i),   W'(prog_count),  W'(tbl[i].cnt));
            chk($sformatf("v%0d terr", i),  W'(timeout_err), W'(tbl[i].terr));
            chk($sformatf("v%0d ovr", i),   W'(overrun),     W'(tbl[i].ovr));
            chk($sformatf("v%0d cfg", i),   cfg_out,         img(tbl[i].cfg));
        end
        host_req = 1'b0; err_clr = 1'b0; done_man = 1'b0;

        // Timeout with a same-cycle err_clr, late done, input image changed mid-frame
        img_keep = img_host;
        host_req = 1'b1;
        step();
        step();
        chk("to latch cfg", cfg_out, img_keep);
        img_host = ~img_keep;
        step();
        chk("to start", W'(shift_start), W'(1));
        step();
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("to wait%0d done", k), W'(done_pulse), '0);
            chk($sformatf("to wait%0d busy", k), W'(busy), W'(1));
        end
        chk("to cfg held", cfg_out, img_keep);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to done", W'(done_pulse), W'(1));
        chk("to terr set wins", W'(timeout_err), W'(1));
        chk("to cnt", W'(prog_count), W'(16'd3));
        done_man = 1'b1;
        step();
        chk("to idle busy", W'(busy), '0);
        step();
        done_man = 1'b0;
        chk("late done cnt", W'(prog_count), W'(16'd3));
        chk("late done busy", W'(busy), '0);
        host_req = 1'b0;
        img_host = img_keep;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("terr cleared", W'(timeout_err), '0);

        // Asynchronous reset in the middle of WAIT
        host_req = 1'b1;
        step(); step(); step(); step(); step();
        chk("pre-rst busy", W'(busy), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy",  W'(busy),        '0);
        chk("arst start", W'(shift_start), '0);
        chk("arst done",  W'(done_pulse),  '0);
        chk("arst sel",   W'(cfg_sel),     '0);
        chk("arst cnt",   W'(prog_count),  '0);
        chk("arst terr",  W'(timeout_err), '0);
        chk("arst ovr",   W'(overrun),     '0);
        chk("arst cfg",   cfg_out,         '0);
        host_req = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            chk($sformatf("quiet%0d start", k), W'(shift_start), '0);
        end
        chk("quiet busy", W'(busy), '0);

        // Counter saturation on the preloaded instance
        host_frame();
        chk("sat1 cnt", W'(prog_count), W'(16'd1));
        chk("sat1 s_cnt", W'(s_prog_count), W'(16'hFFFE));
        host_frame();
        chk("sat2 cnt", W'(prog_count), W'(16'd2));
        chk("sat2 s_cnt", W'(s_prog_count), W'(16'hFFFF));
        host_frame();
        chk("sat3 cnt", W'(prog_count), W'(16'd3));
        chk("sat3 s_cnt", W'(s_prog_count), W'(16'hFFFF));

        // Periodic auto-reprogram alternating between the two SEU images
        do_reset();
        model_en = 1'b1;
        auto_en  = 1'b1;
        n_ev = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            chk($sformatf("per%0d start", i), W'(shift_start),
                W'((i >= 17) && ((i - 17) % 16 == 0)));
            if (shift_start) begin
                chk($sformatf("per ev%0d sel", n_ev), W'(cfg_sel), W'((n_ev % 2) + 1));
                chk($sformatf("per ev%0d cfg", n_ev), cfg_out, img((n_ev % 2) + 1));
                n_ev++;
            end
        end
        chk("per events", W'(n_ev), W'(4));
        chk("per cnt", W'(prog_count), W'(16'd4));
        auto_en = 1'b0;

        // Host edge and prescaler tick in the same cycle
        do_reset();
        model_en = 1'b1;
        auto_en  = 1'b1;
        for (int i = 0; i < 15; i++) step();
        host_req = 1'b1;
        step();
        auto_en = 1'b0;
        n_ev = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (shift_start) begin
                if (n_ev == 0) begin
                    chk("coll first sel", W'(cfg_sel), '0);
                    chk("coll first cfg", cfg_out, img_host);
                end else begin
                    chk($sformatf("coll ev%0d sel", n_ev), W'(cfg_sel), W'(1));
                    chk($sformatf("coll ev%0d cfg", n_ev), cfg_out, img_s0);
                end
                n_ev++;
            end
        end
        chk("coll events", W'(n_ev), W'(2));
        chk("coll cnt", W'(prog_count), W'(16'd2));
        chk("coll busy", W'(busy), '0);
        host_req = 1'b0;
        model_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
